mem_stage_ctrl: RTL and testbench

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

---
 rtl/lc3b_types.sv | 28 ++
 rtl/mem_stage_ctrl_if.sv | 24 ++
 rtl/mem_byte_align.sv | 26 ++
 rtl/mem_stage_ctrl.sv | 146 ++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types, control-store bit indices and MEM-stage state enum.
// IND_PTR exists only when INDIRECT_EN is defined.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [10:0] lc3b_eleven;
    typedef logic [2:0]  lc3b_nzp;

    localparam int CS_MEM_READ     = 0;
    localparam int CS_MEM_WRITE    = 1;
    localparam int CS_MEM_BYTE     = 2;
    localparam int CS_MEM_INDIRECT = 3;
    localparam int CS_REGWE        = 4;

`ifdef INDIRECT_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IND_PTR = 2'd1,
        ACCESS  = 2'd2
    } mem_state_e;
`else
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd2
    } mem_state_e;
`endif

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-cache request/response bundle between the MEM stage and the cache.
interface mem_stage_ctrl_if;
    import lc3b_types::*;

    logic       dmem_read;
    logic       dmem_write;
    lc3b_word   dmem_address;
    lc3b_word   dmem_wdata;
    logic [1:0] dmem_byte_enable;
    lc3b_word   dmem_rdata;
    logic       dmem_resp;

    modport master (
        output dmem_read, dmem_write, dmem_address,
        output dmem_wdata, dmem_byte_enable,
        input  dmem_rdata, dmem_resp
    );

    modport slave (
        input  dmem_read, dmem_write, dmem_address,
        input  dmem_wdata, dmem_byte_enable,
        output dmem_rdata, dmem_resp
    );
endinterface

// File: rtl/mem_byte_align.sv
// Byte-lane steering: enables, store replication, load select/sign-extend.
module mem_byte_align
    import lc3b_types::*;
(
    input  logic       byte_op,
    input  logic       addr0,
    input  lc3b_word   store_data,
    input  lc3b_word   rdata,
    output logic [1:0] byte_enable,
    output lc3b_word   wdata,
    output lc3b_word   load_data
);
    logic [7:0] sel;

    always_comb begin
        sel         = addr0 ? rdata[15:8] : rdata[7:0];
        byte_enable = 2'b11;
        wdata       = store_data;
        load_data   = rdata;
        if (byte_op) begin
            byte_enable = addr0 ? 2'b10 : 2'b01;
            wdata       = {store_data[7:0], store_data[7:0]};
            load_data   = {{8{sel[7]}}, sel};
        end
    end
endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: data-cache sequencing and WB latch.
// INDIRECT_EN adds the pointer-fetch state for indirect loads/stores.
module mem_stage_ctrl
    import lc3b_types::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mem_valid,
    input  lc3b_eleven              mem_cs,
    input  lc3b_word                mem_address,
    input  lc3b_word                mem_aluresult,
    input  lc3b_word                mem_ir,
    input  lc3b_nzp                 mem_drid,
    mem_stage_ctrl_if.master        dmem,
    output logic                    stall,
    output logic                    wb_valid,
    output lc3b_word                wb_data,
    output lc3b_nzp                 wb_drid,
    output logic                    wb_regwe,
    output lc3b_word                wb_ir
);
    mem_state_e state_q, state_d;
    lc3b_word   addr_q, sdata_q, ir_q;
    lc3b_eleven cs_q;
    lc3b_nzp    drid_q;

    logic       memop, byte_op, is_read, rd, wr, stall_c;
    logic [1:0] al_be, be;
    lc3b_word   al_wdata, load_data, addr_o, wdata_o;
    logic       unused_cs;

    assign memop     = mem_cs[CS_MEM_READ] | mem_cs[CS_MEM_WRITE];
    assign is_read   = cs_q[CS_MEM_READ];
    assign byte_op   = (state_q == ACCESS) & cs_q[CS_MEM_BYTE];
    assign unused_cs = ^{cs_q[10:5], cs_q[CS_MEM_INDIRECT]};

    mem_byte_align u_align (
        .byte_op     (byte_op),
        .addr0       (addr_q[0]),
        .store_data  (sdata_q),
        .rdata       (dmem.dmem_rdata),
        .byte_enable (al_be),
        .wdata       (al_wdata),
        .load_data   (load_data)
    );

    always_comb begin
        state_d = state_q;
        stall_c = 1'b0;
        rd      = 1'b0;
        wr      = 1'b0;
        addr_o  = '0;
        wdata_o = '0;
        be      = 2'b00;
        unique case (state_q)
            IDLE: begin
                if (mem_valid && memop) begin
                    stall_c = 1'b1;
`ifdef INDIRECT_EN
                    state_d = mem_cs[CS_MEM_INDIRECT] ? IND_PTR : ACCESS;
`else
                    state_d = ACCESS;
`endif
                end
            end
`ifdef INDIRECT_EN
            IND_PTR: begin
                stall_c = 1'b1;
                rd      = 1'b1;
                addr_o  = {addr_q[15:1], 1'b0};
                be      = al_be;
                if (dmem.dmem_resp) state_d = ACCESS;
            end
`endif
            ACCESS: begin
                // read wins when a malformed cs sets both
                rd      = is_read;
                wr      = cs_q[CS_MEM_WRITE] & ~is_read;
                addr_o  = byte_op ? addr_q : {addr_q[15:1], 1'b0};
                be      = al_be;
                wdata_o = wr ? al_wdata : '0;
                stall_c = ~dmem.dmem_resp;
                if (dmem.dmem_resp) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall                 = stall_c & rst_n;
    assign dmem.dmem_read        = rd;
    assign dmem.dmem_write       = wr;
    assign dmem.dmem_address     = addr_o;
    assign dmem.dmem_wdata       = wdata_o;
    assign dmem.dmem_byte_enable = be;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            sdata_q  <= '0;
            ir_q     <= '0;
            cs_q     <= '0;
            drid_q   <= '0;
            wb_valid <= 1'b0;
            wb_data  <= '0;
            wb_drid  <= '0;
            wb_regwe <= 1'b0;
            wb_ir    <= '0;
        end else begin
            state_q  <= state_d;
            wb_valid <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (mem_valid && memop) begin
                        addr_q  <= mem_address;
                        sdata_q <= mem_aluresult;
                        cs_q    <= mem_cs;
                        ir_q    <= mem_ir;
                        drid_q  <= mem_drid;
                    end else if (mem_valid) begin
                        wb_valid <= 1'b1;
                        wb_data  <= mem_aluresult;
                        wb_drid  <= mem_drid;
                        wb_ir    <= mem_ir;
                        wb_regwe <= mem_cs[CS_REGWE];
                    end
                end
`ifdef INDIRECT_EN
                IND_PTR: begin
                    if (dmem.dmem_resp) addr_q <= dmem.dmem_rdata;
                end
`endif
                ACCESS: begin
                    if (dmem.dmem_resp) begin
                        wb_valid <= 1'b1;
                        wb_regwe <= cs_q[CS_REGWE] & is_read;
                        wb_drid  <= drid_q;
                        wb_ir    <= ir_q;
                        if (is_read) wb_data <= load_data;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with a transaction-level expectation model.
// Honors INDIRECT_EN the same way the design does.
module tb_mem_stage_ctrl;
    import lc3b_types::*;

`ifdef INDIRECT_EN
    localparam bit IND_EN = 1'b1;
`else
    localparam bit IND_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       mem_valid;
    lc3b_eleven mem_cs;
    lc3b_word   mem_address, mem_aluresult, mem_ir;
    lc3b_nzp    mem_drid;
    logic       stall, wb_valid, wb_regwe;
    lc3b_word   wb_data, wb_ir;
    lc3b_nzp    wb_drid;

    mem_stage_ctrl_if dif();

    mem_stage_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_valid     (mem_valid),
        .mem_cs        (mem_cs),
        .mem_address   (mem_address),
        .mem_aluresult (mem_aluresult),
        .mem_ir        (mem_ir),
        .mem_drid      (mem_drid),
        .dmem          (dif.master),
        .stall         (stall),
        .wb_valid      (wb_valid),
        .wb_data       (wb_data),
        .wb_drid       (wb_drid),
        .wb_regwe      (wb_regwe),
        .wb_ir         (wb_ir)
    );

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    // current-cycle combinational expectations
    bit         e_stall, e_rd, e_wr;
    lc3b_word   e_addr, e_wd;
    logic [1:0] e_be;
    // registered expectations: n_* for next edge, c_* visible now
    bit         n_v, n_re, n_dchk, c_v, c_re, c_dchk;
    lc3b_word   n_d, n_ir, c_d, c_ir;
    lc3b_nzp    n_dr, c_dr;

    int         stall_cnt;
    lc3b_word   seen_addr, seen_wd;
    logic [1:0] seen_be;

    task automatic chk(input string n, input logic [15:0] a,
                       input logic [15:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
        end
    endtask

    task automatic clr_exp();
        e_stall = 0; e_rd = 0; e_wr = 0;
        e_addr = '0; e_wd = '0; e_be = '0;
        n_v = 0; n_re = 0; n_dchk = 0;
        n_d = '0; n_dr = '0; n_ir = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        c_v = n_v; c_re = n_re; c_dchk = n_dchk;
        c_d = n_d; c_dr = n_dr; c_ir = n_ir;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", 16'(stall), 16'(e_stall));
            chk("dmem_read", 16'(dif.dmem_read), 16'(e_rd));
            chk("dmem_write", 16'(dif.dmem_write), 16'(e_wr));
            chk("rd_wr_excl", 16'(dif.dmem_read & dif.dmem_write), 16'd0);
            if (e_rd || e_wr) begin
                chk("dmem_address", dif.dmem_address, e_addr);
                chk("byte_enable", 16'(dif.dmem_byte_enable), 16'(e_be));
            end
            if (e_wr) chk("dmem_wdata", dif.dmem_wdata, e_wd);
            chk("wb_valid", 16'(wb_valid), 16'(c_v));
            if (c_v) begin
                chk("wb_drid", 16'(wb_drid), 16'(c_dr));
                chk("wb_ir", wb_ir, c_ir);
                chk("wb_regwe", 16'(wb_regwe), 16'(c_re));
                if (c_dchk) chk("wb_data", wb_data, c_d);
            end
            if (stall) stall_cnt++;
            if (dif.dmem_read || dif.dmem_write) begin
                seen_addr = dif.dmem_address;
                seen_be   = dif.dmem_byte_enable;
                seen_wd   = dif.dmem_wdata;
            end
        end
    end

    task automatic idle(input bit resp);
        tick();
        mem_valid = 1'b0;
        dif.dmem_resp = resp;
        dif.dmem_rdata = 16'($urandom);
        clr_exp();
    endtask

    task automatic access(input bit rd, input bit wr, input lc3b_word a,
                          input logic [1:0] be, input lc3b_word wd,
                          input lc3b_word r, input int waits,
                          input bit last, input lc3b_word res,
                          input bit regwe, input lc3b_nzp dr,
                          input lc3b_word ir);
        for (int w = 0; w <= waits; w++) begin
            tick();
            dif.dmem_resp  = (w == waits);
            dif.dmem_rdata = (w == waits) ? r : 16'($urandom);
            e_rd = rd; e_wr = wr; e_addr = a; e_be = be; e_wd = wd;
            e_stall = !(last && w == waits);
            n_v = last && (w == waits);
            n_re = regwe; n_dchk = rd; n_d = res;
            n_dr = dr; n_ir = ir;
        end
    endtask

    // one instruction; the upstream latch holds it while stall is high
    task automatic run_op(input lc3b_eleven cs, input lc3b_word a,
                          input lc3b_word d, input lc3b_word ir,
                          input lc3b_nzp dr, input lc3b_word ptr,
                          input lc3b_word fin, input int waits);
        bit         rd, wr, byt;
        lc3b_word   base, fa, wd, res;
        logic [1:0] fbe;
        logic [7:0] sel;
        tick();
        mem_valid = 1'b1; mem_cs = cs; mem_address = a;
        mem_aluresult = d; mem_ir = ir; mem_drid = dr;
        dif.dmem_resp = 1'b0;
        clr_exp();
        rd = cs[0];
        wr = cs[1] && !rd;
        if (!(cs[0] || cs[1])) begin
            n_v = 1; n_re = cs[4]; n_dchk = 1;
            n_d = d; n_dr = dr; n_ir = ir;
            return;
        end
        e_stall = 1;
        base = a;
        if (IND_EN && cs[3]) begin
            access(1'b1, 1'b0, a & 16'hFFFE, 2'b11, 16'h0, ptr, waits,
                   1'b0, 16'h0, 1'b0, dr, ir);
            base = ptr;
        end
        byt = cs[2];
        fa  = byt ? base : (base & 16'hFFFE);
        fbe = byt ? (base[0] ? 2'b10 : 2'b01) : 2'b11;
        wd  = byt ? {d[7:0], d[7:0]} : d;
        sel = base[0] ? fin[15:8] : fin[7:0];
        res = byt ? {{8{sel[7]}}, sel} : fin;
        access(rd, wr, fa, fbe, wd, fin, waits, 1'b1, res,
               cs[4] && rd, dr, ir);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        mem_valid = 0; mem_cs = '0; mem_address = '0;
        mem_aluresult = '0; mem_ir = '0; mem_drid = '0;
        dif.dmem_resp = 0; dif.dmem_rdata = '0;
        clr_exp();
        c_v = 0; c_re = 0; c_dchk = 0; c_d = '0; c_dr = '0; c_ir = '0;
        stall_cnt = 0; seen_addr = '0; seen_be = '0; seen_wd = '0;

        @(negedge clk);
        chk("rst_wb_valid", 16'(wb_valid), 16'd0);
        chk("rst_stall", 16'(stall), 16'd0);
        chk("rst_read", 16'(dif.dmem_read), 16'd0);
        chk("rst_write", 16'(dif.dmem_write), 16'd0);
        chk("rst_wb_data", wb_data, 16'h0);
        chk("rst_wb_regwe", 16'(wb_regwe), 16'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        idle(0);
        idle(0);

        stall_cnt = 0;
        run_op(11'h010, 16'h0000, 16'h1234, 16'h1A2B, 3'd3, 0, 0, 0);
        idle(0);
        chk("alu_wb_valid", 16'(wb_valid), 16'd1);
        chk("alu_wb_data", wb_data, 16'h1234);
        chk("alu_wb_drid", 16'(wb_drid), 16'd3);
        chk("alu_stall_cnt", 16'(stall_cnt), 16'd0);

        stall_cnt = 0;
        run_op(11'h011, 16'h0105, 16'h0, 16'h6A45, 3'd5, 0, 16'h8001, 3);
        idle(0);
        chk("ldr_addr", seen_addr, 16'h0104);
        chk("ldr_stall_cnt", 16'(stall_cnt), 16'd4);
        chk("ldr_wb_data", wb_data, 16'h8001);

        run_op(11'h015, 16'h0101, 16'h0, 16'h2243, 3'd1, 0, 16'h80FF, 1);
        idle(0);
        chk("ldb_be", 16'(seen_be), 16'h2);
        chk("ldb_wb_data", wb_data, 16'hFF80);

        run_op(11'h006, 16'h0100, 16'h00AB, 16'h3C40, 3'd0, 0, 16'h0, 0);
        idle(0);
        chk("stb_wdata", seen_wd, 16'hABAB);
        chk("stb_be", 16'(seen_be), 16'h1);
        chk("stb_wb_regwe", 16'(wb_regwe), 16'd0);

        run_op(11'h019, 16'h0200, 16'h0, 16'hA400, 3'd2,
               16'h3000, 16'h0042, 2);
        idle(0);
        chk("ldi_addr", seen_addr, IND_EN ? 16'h3000 : 16'h0200);
        chk("ldi_wb_data", wb_data, 16'h0042);

        run_op(11'h002, 16'h0333, 16'hBEEF, 16'h7200, 3'd0, 0, 0, 1);
        run_op(11'h010, 16'h0000, 16'h5555, 16'h1111, 3'd6, 0, 0, 0);
        run_op(11'h013, 16'h0010, 16'h7777, 16'h6111, 3'd7, 0, 16'hC3C3, 0);
        idle(1);
        idle(1);
        run_op(11'h015, 16'h0200, 16'h0, 16'h2000, 3'd4, 0, 16'h1234, 2);
        run_op(11'h000, 16'h0000, 16'h9999, 16'h0000, 3'd2, 0, 0, 0);
        idle(0);

        // reset in the middle of a load
        tick();
        mem_valid = 1; mem_cs = 11'h011; mem_address = 16'h0105;
        mem_aluresult = '0; mem_ir = 16'h6A45; mem_drid = 3'd1;
        dif.dmem_resp = 0;
        clr_exp();
        e_stall = 1;
        tick();
        e_rd = 1; e_addr = 16'h0104; e_be = 2'b11; e_stall = 1;
        #2;
        chk("rst_mid_read_pre", 16'(dif.dmem_read), 16'd1);
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_read", 16'(dif.dmem_read), 16'd0);
        chk("rst_mid_write", 16'(dif.dmem_write), 16'd0);
        chk("rst_mid_stall", 16'(stall), 16'd0);
        chk("rst_mid_wb_valid", 16'(wb_valid), 16'd0);
        mem_valid = 0;
        clr_exp();
        @(negedge clk);
        rst_n = 1'b1;
        idle(0);
        chk_en = 1'b1;
        repeat (4) idle(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
